eth_fifo_arbiter: RTL
=====================

Name: eth_fifo_arbiter

Overview:
- Schedules N peripheral 64-bit show-ahead FIFOs onto one shared Avalon-ST source that feeds the Ethernet packet path.
- Grants one FIFO at a time, round-robin, and drains a bounded burst from it as one packet framed with startofpacket/endofpacket.
- A source requests service when its FIFO is full, or when it has held data for FLUSH_TIMEOUT cycles without being served.

Parameters:
- N_SRC, 4, number of source FIFOs (2..8).
- DATA_W, 64, data width per source.
- USEDW_W, 9, width of each FIFO fill-level input.
- MAX_PKT, 256, maximum beats per packet (≤ 2^USEDW_W - 1).
- FLUSH_TIMEOUT, 1024, idle-with-data cycles before a forced request; 0 disables the timeout.

Ports:
- csi_clk  in  1  single clock; all logic on rising edge.
- rsi_reset  in  1  synchronous, active-high reset.
- fifo_data  in  N_SRC*DATA_W  show-ahead head word per source; source i at bits [i*DATA_W +: DATA_W].
- fifo_usedw  in  N_SRC*USEDW_W  fill level per source.
- fifo_empty  in  N_SRC  per-source empty.
- fifo_full  in  N_SRC  per-source full.
- fifo_read  out  N_SRC  per-source read acknowledge.
- asi_ready  in  1  downstream ready.
- asi_valid  out  1  beat valid.
- asi_data  out  DATA_W  beat data.
- asi_startofpacket  out  1  first beat of packet.
- asi_endofpacket  out  1  last beat of packet.
- asi_channel  out  $clog2(N_SRC)  index of granted source.
- grant_active  out  1  high while a packet is in progress.

Behaviour:
- Reset: state IDLE; all outputs 0; last_grant = N_SRC-1, so source 0 has first priority; all timeout counters 0; all pending flags 0.
- Reset asserted mid-packet aborts the packet immediately. No eop is emitted; the downstream consumer is also reset.
- Request logic:
  - req[i] = fifo_full[i] | pend[i].
  - Timeout counter i increments each cycle that !fifo_empty[i] and source i is not granted. It clears when fifo_empty[i] or when i is granted.
  - pend[i] sets when the counter reaches FLUSH_TIMEOUT and clears on grant to i. The counter saturates.
- FSM states IDLE, SEND:
  - IDLE: if any req, select the first requester searching from last_grant+1 with wrap-around.
    - Latch sel, len = min(fifo_usedw[sel], MAX_PKT), beat = 0.
    - Go to SEND next cycle. asi_valid stays 0 in IDLE.
    - A requester with usedw = 0 (empty despite pend) is skipped. Its pend clears.
  - SEND: asi_valid = 1 combinationally.
    - asi_data = fifo_data[sel]; asi_channel = sel.
    - asi_startofpacket = (beat == 0); asi_endofpacket = (beat == len-1).
    - fifo_read[sel] = asi_valid & asi_ready, zero-cycle, same cycle as the beat. All other fifo_read bits are 0.
    - On each accepted beat, beat increments. On the accepted eop beat: last_grant = sel, return to IDLE.
- Data availability: len ≤ usedw at grant and sources only write, so the FIFO never empties inside a packet. An assertion flags fifo_empty[sel] while in SEND.
- Backpressure: with asi_ready low, all outputs hold and no read occurs.
- Packet-to-packet gap is exactly one IDLE cycle.
- Single-beat packet (len = 1): sop and eop are both high on the same beat.
- A full source is re-requested immediately after its packet if it is still full. Round-robin still serves other requesters first.
- Simultaneous full and timeout on one source: treated as a single request.
- Widths: beat and len are $clog2(MAX_PKT+1) bits wide. MAX_PKT compares against usedw zero-extended.

Decomposition:
- Package eth_arb_pkg:
  - FSM state enum (IDLE, SEND).
  - Localparams for index width and beat-counter width.
  - Function min_len(usedw, max).
- Sub-module rr_arbiter (N-bit request vector, last_grant in, one-hot grant plus index out, purely combinational). Reusable by other shared-port blocks.
- Timeout counters stay inline in a generate loop.

Test Plan:
- Reset with all FIFOs empty → outputs 0 for 20 cycles; no fifo_read.
- Source 2 full with usedw = 300, asi_ready constantly 1 → one IDLE cycle, then 256 beats with asi_channel = 2, sop on beat 0, eop on beat 255, fifo_read[2] high for 256 cycles.
- Sources 0, 1, 3 full simultaneously, MAX_PKT = 4 → packets in order 0, 1, 3, 0, …, each 4 beats, one-cycle gap between packets.
- Source 1 holds 3 words, not full, FLUSH_TIMEOUT = 16 → packet starts at cycle 17 after the first word arrives; 3 beats; eop on beat 2.
- asi_ready toggling at random 50% during a 10-beat packet → data identical to FIFO order; fifo_read only on ready&valid cycles; no beat duplicated or dropped.
- rsi_reset asserted on beat 5 of a packet → next cycle asi_valid = 0, state IDLE, last_grant = N_SRC-1.

Source files
------------

// File: rtl/eth_arb_pkg.sv
// Shared types and helpers for the Ethernet FIFO arbiter and its round-robin picker.
package eth_arb_pkg;

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_SEND = 1'b1
   } arb_state_e;

   localparam int N_SRC_DEF   = 4;
   localparam int MAX_PKT_DEF = 256;
   localparam int IDX_W_DEF   = $clog2(N_SRC_DEF);
   localparam int BEAT_W_DEF  = $clog2(MAX_PKT_DEF + 1);

   function automatic int unsigned min_len(input int unsigned usedw, input int unsigned max_len);
      return (usedw < max_len) ? usedw : max_len;
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first request after last_grant, with wrap-around.
module rr_arbiter
   import eth_arb_pkg::*;
#(
   parameter int N_REQ = N_SRC_DEF,
   parameter int IDX_W = IDX_W_DEF
) (
   input  logic [N_REQ-1:0] req,
   input  logic [IDX_W-1:0] last_grant,
   output logic [N_REQ-1:0] grant,
   output logic [IDX_W-1:0] grant_idx,
   output logic             grant_valid
);

   int               idx_i;
   logic [IDX_W-1:0] idx;

   always_comb begin
      grant       = '0;
      grant_idx   = '0;
      grant_valid = 1'b0;
      idx_i       = 0;
      idx         = '0;
      for (int k = 1; k <= N_REQ; k++) begin
         idx_i = (int'(last_grant) + k) % N_REQ;
         idx   = IDX_W'(idx_i);
         if (!grant_valid && req[idx]) begin
            grant[idx]  = 1'b1;
            grant_idx   = idx;
            grant_valid = 1'b1;
         end
      end
   end

endmodule

// File: rtl/eth_fifo_arbiter.sv
// Round-robin scheduler draining show-ahead source FIFOs as framed packets onto one
// Avalon-ST source. Sources request when full or after sitting on data too long.
//
// state   | meaning
// ST_IDLE | no packet open; pick next requester, latch its packet length
// ST_SEND | streaming beats from sel_q until the eop beat is accepted
module eth_fifo_arbiter
   import eth_arb_pkg::*;
#(
   parameter int N_SRC         = N_SRC_DEF,
   parameter int DATA_W        = 64,
   parameter int USEDW_W       = 9,
   parameter int MAX_PKT       = MAX_PKT_DEF,
   parameter int FLUSH_TIMEOUT = 1024
) (
   input  logic                        csi_clk,
   input  logic                        rsi_reset,
   input  logic [N_SRC*DATA_W-1:0]     fifo_data,
   input  logic [N_SRC*USEDW_W-1:0]    fifo_usedw,
   input  logic [N_SRC-1:0]            fifo_empty,
   input  logic [N_SRC-1:0]            fifo_full,
   output logic [N_SRC-1:0]            fifo_read,
   input  logic                        asi_ready,
   output logic                        asi_valid,
   output logic [DATA_W-1:0]           asi_data,
   output logic                        asi_startofpacket,
   output logic                        asi_endofpacket,
   output logic [$clog2(N_SRC)-1:0]    asi_channel,
   output logic                        grant_active
);

   localparam int IDX_W  = $clog2(N_SRC);
   localparam int BEAT_W = $clog2(MAX_PKT + 1);
   localparam int TO_W   = (FLUSH_TIMEOUT > 0) ? $clog2(FLUSH_TIMEOUT + 1) : 1;

   arb_state_e         state_q;
   logic [IDX_W-1:0]   sel_q;
   logic [IDX_W-1:0]   last_grant_q;
   logic [BEAT_W-1:0]  len_q;
   logic [BEAT_W-1:0]  beat_q;
   logic [BEAT_W-1:0]  len_d;

   logic [N_SRC-1:0]   pend;
   logic [N_SRC-1:0]   req;
   logic [N_SRC-1:0]   arb_grant;
   logic [IDX_W-1:0]   arb_idx;
   logic               arb_valid;
   logic [N_SRC-1:0]   served;
   logic [N_SRC-1:0]   in_service;

   logic [USEDW_W-1:0] cand_usedw;
   logic [DATA_W-1:0]  sel_data;
   logic               pick;
   logic               beat_acc;
   logic               last_beat;

   assign req = fifo_full | pend;

   rr_arbiter #(
      .N_REQ (N_SRC),
      .IDX_W (IDX_W)
   ) u_rr_arbiter (
      .req         (req),
      .last_grant  (last_grant_q),
      .grant       (arb_grant),
      .grant_idx   (arb_idx),
      .grant_valid (arb_valid)
   );

   always_comb begin
      cand_usedw = '0;
      sel_data   = '0;
      for (int i = 0; i < N_SRC; i++) begin
         if (arb_idx == IDX_W'(i)) cand_usedw = fifo_usedw[i*USEDW_W +: USEDW_W];
         if (sel_q == IDX_W'(i))   sel_data   = fifo_data[i*DATA_W +: DATA_W];
      end
   end

   assign pick      = (state_q == ST_IDLE) && arb_valid;
   assign len_d     = BEAT_W'(min_len(32'(cand_usedw), 32'(MAX_PKT)));
   assign asi_valid = (state_q == ST_SEND);
   assign beat_acc  = asi_valid && asi_ready;
   assign last_beat = (beat_q == len_q - 1'b1);

   always_comb begin
      served     = '0;
      in_service = '0;
      fifo_read  = '0;
      for (int i = 0; i < N_SRC; i++) begin
         served[i]     = pick && arb_grant[i];
         in_service[i] = served[i] || (asi_valid && (sel_q == IDX_W'(i)));
         fifo_read[i]  = beat_acc && (sel_q == IDX_W'(i));
      end
   end

   assign asi_data          = asi_valid ? sel_data : '0;
   assign asi_channel       = asi_valid ? sel_q : '0;
   assign asi_startofpacket = asi_valid && (beat_q == '0);
   assign asi_endofpacket   = asi_valid && last_beat;
   assign grant_active      = asi_valid;

   // Flush timers: a source sitting on data unserved eventually forces a request.
   if (FLUSH_TIMEOUT > 0) begin : g_to
      for (genvar i = 0; i < N_SRC; i++) begin : g_src
         logic [TO_W-1:0] cnt_q;
         logic            pend_q;

         always_ff @(posedge csi_clk) begin
            if (rsi_reset) begin
               cnt_q  <= '0;
               pend_q <= 1'b0;
            end else begin
               if (fifo_empty[i] || in_service[i]) begin
                  cnt_q <= '0;
               end else if (cnt_q != TO_W'(FLUSH_TIMEOUT)) begin
                  cnt_q <= cnt_q + 1'b1;
               end

               if (served[i]) begin
                  pend_q <= 1'b0;
               end else if (!fifo_empty[i] && !in_service[i] &&
                            (cnt_q == TO_W'(FLUSH_TIMEOUT - 1))) begin
                  pend_q <= 1'b1;
               end
            end
         end

         assign pend[i] = pend_q;
      end
   end else begin : g_no_to
      assign pend = '0;
   end

   always_ff @(posedge csi_clk) begin
      if (rsi_reset) begin
         state_q      <= ST_IDLE;
         sel_q        <= '0;
         last_grant_q <= IDX_W'(N_SRC - 1);
         len_q        <= '0;
         beat_q       <= '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (arb_valid) begin
                  if (cand_usedw != '0) begin
                     sel_q   <= arb_idx;
                     len_q   <= len_d;
                     beat_q  <= '0;
                     state_q <= ST_SEND;
                  end else begin
                     // Nothing to send: move the pointer so a stuck source cannot starve others.
                     last_grant_q <= arb_idx;
                  end
               end
            end
            ST_SEND: begin
               if (beat_acc) begin
                  beat_q <= beat_q + 1'b1;
                  if (last_beat) begin
                     last_grant_q <= sel_q;
                     state_q      <= ST_IDLE;
                  end
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   a_no_underflow: assert property (@(posedge csi_clk) disable iff (rsi_reset)
      (state_q == ST_SEND) |-> !fifo_empty[sel_q]);

endmodule
